// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit for the multicycle MIPS datapath (MULT/MULTU/DIV/DIVU).
// Shift-add multiply and restoring divide, one bit per clock, results land in HI/LO.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [STEP_W-1:0]    step_r;
    logic                 op_div_r;
    logic                 neg_lo_r;
    logic                 neg_hi_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 div_zero_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 op_valid_s;
    logic                 op_div_s;
    logic                 op_signed_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   mul_res_s;
    logic [WIDTH-1:0]     quo_res_s;
    logic [WIDTH-1:0]     rem_res_s;
    logic [WIDTH-1:0]     hi_next_s;
    logic [WIDTH-1:0]     lo_next_s;

    // Signed operands are processed as magnitudes; the sign is re-applied at the end.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Decode the R-type funct into operation class and signedness.
    always_comb begin
        op_valid_s  = 1'b0;
        op_div_s    = 1'b0;
        op_signed_s = 1'b0;
        case (funct)
            6'h18: begin op_valid_s = 1'b1; op_div_s = 1'b0; op_signed_s = 1'b1; end
            6'h19: begin op_valid_s = 1'b1; op_div_s = 1'b0; op_signed_s = 1'b0; end
            6'h1A: begin op_valid_s = 1'b1; op_div_s = 1'b1; op_signed_s = 1'b1; end
            6'h1B: begin op_valid_s = 1'b1; op_div_s = 1'b1; op_signed_s = 1'b0; end
            default: begin op_valid_s = 1'b0; op_div_s = 1'b0; op_signed_s = 1'b0; end
        endcase
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_r};
        if (op_div_r) begin
            if (div_diff_s[WIDTH]) begin
                acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end else begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign-correct the final iteration's result so HI/LO can be written on FINISH entry.
    always_comb begin
        mul_res_s = neg_lo_r ? -acc_next_s : acc_next_s;
        quo_res_s = neg_lo_r ? -acc_next_s[WIDTH-1:0] : acc_next_s[WIDTH-1:0];
        rem_res_s = neg_hi_r ? -acc_next_s[2*WIDTH-1:WIDTH] : acc_next_s[2*WIDTH-1:WIDTH];
        if (op_div_r) begin
            hi_next_s = rem_res_s;
            lo_next_s = quo_res_s;
        end else begin
            hi_next_s = mul_res_s[2*WIDTH-1:WIDTH];
            lo_next_s = mul_res_s[WIDTH-1:0];
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            acc_r      <= {(2*WIDTH){1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            step_r     <= {STEP_W{1'b0}};
            op_div_r   <= 1'b0;
            neg_lo_r   <= 1'b0;
            neg_hi_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && op_valid_s) begin
                        op_div_r <= op_div_s;
                        busy_r   <= 1'b1;
                        if (op_div_s && (b == {WIDTH{1'b0}})) begin
                            // Divide by zero: skip iterations, HI/LO keep their old values.
                            state_r    <= FINISH;
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                        end else begin
                            state_r    <= CALC;
                            div_zero_r <= 1'b0;
                            acc_r      <= {{WIDTH{1'b0}}, magnitude(a, op_signed_s)};
                            mcand_r    <= magnitude(b, op_signed_s);
                            step_r     <= {STEP_W{1'b0}};
                            neg_lo_r   <= op_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_r   <= op_signed_s & a[WIDTH-1];
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r  <= acc_next_s;
                    step_r <= step_r + STEP_W'(1);
                    if (step_r == STEP_W'(WIDTH-1)) begin
                        state_r <= FINISH;
                        done_r  <= 1'b1;
                        hi_r    <= hi_next_s;
                        lo_r    <= lo_next_s;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed-vector bench for mult_div_seq: results, latency, busy/done shape, div-by-zero,
// reset mid-operation and ignored start requests.
module tb_mult_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int done_cnt   = 0;
    int lat;
    int bcnt;
    int cnt0;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op; a/b are scrambled after the start edge. Optionally pokes start mid-CALC.
    task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int poke, output int latency, output int busy_seen);
        @(negedge clk);
        funct = f; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = ~bv;
        latency = 1; busy_seen = 0;
        while (!done && latency < 100) begin
            if (busy) busy_seen++;
            if (latency == poke) begin
                start = 1'b1; funct = 6'h18;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            latency++;
        end
        start = 1'b0;
        if (busy) busy_seen++;
        check("done_seen", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        check("idle_after_finish", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct = 6'h00; a = 32'd0; b = 32'd0;
        #12;
        check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op(6'h1B, 32'd100, 32'd7, 0, lat, bcnt);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

        // Reset 10 cycles into a MULT abandons it and clears HI/LO.
        @(negedge clk);
        funct = 6'h18; a = 32'd7; b = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("midreset_idle", {62'd0, busy, done}, 64'd0);
        run_op(6'h19, 32'd3, 32'd5, 0, lat, bcnt);
        check("multu_3_5", {hi, lo}, {32'd0, 32'd15});

        run_op(6'h18, 32'd7, 32'hFFFF_FFFD, 0, lat, bcnt);
        check("mult_latency", lat, 64'd33);
        check("mult_busy_cycles", bcnt, 64'd33);
        check("mult_7_m3", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

        run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
        check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});

        run_op(6'h18, 32'h8000_0000, 32'h8000_0000, 0, lat, bcnt);
        check("mult_minneg_sq", {hi, lo}, {32'h4000_0000, 32'h0000_0000});

        run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt);
        check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_op(6'h1A, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt);
        check("div_7_m2", {hi, lo}, {32'd1, 32'hFFFF_FFFD});

        run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
        check("div_minneg_m1", {hi, lo}, {32'd0, 32'h8000_0000});
        check("div_minneg_noflag", {63'd0, div_zero}, 64'd0);

        // Divide by zero keeps the previous HI/LO and sets a sticky flag.
        run_op(6'h1B, 32'd100, 32'd7, 0, lat, bcnt);
        check("divu_100_7_again", lat, 64'd33);
        run_op(6'h1A, 32'd5, 32'd0, 0, lat, bcnt);
        check("divzero_latency", lat, 64'd1);
        check("divzero_flag", {63'd0, div_zero}, 64'd1);
        check("divzero_hilo", {hi, lo}, {32'd2, 32'd14});
        run_op(6'h1B, 32'd9, 32'd4, 0, lat, bcnt);
        check("divu_9_4", {hi, lo}, {32'd1, 32'd2});
        check("divzero_cleared", {63'd0, div_zero}, 64'd0);

        // start during CALC is ignored; a single done pulse and unchanged result.
        cnt0 = done_cnt;
        run_op(6'h19, 32'd6, 32'd7, 5, lat, bcnt);
        check("poke_latency", lat, 64'd33);
        check("poke_result", {hi, lo}, {32'd0, 32'd42});
        repeat (40) @(posedge clk);
        #1;
        check("poke_one_done", done_cnt - cnt0, 64'd1);
        check("poke_idle", {62'd0, busy, done}, 64'd0);

        // Unsupported funct in IDLE is ignored.
        @(negedge clk);
        funct = 6'h20; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("badfunct_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("badfunct_no_done", done_cnt - cnt0, 64'd1);
        check("badfunct_hilo", {hi, lo}, {32'd0, 32'd42});

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
